// File: rtl/cpu_ctrl_pkg.sv
// Shared pipeline-control encodings: hazard FSM states, forwarding selects and
// result_sel codes (also used by the decoder and the ID/EX stage).
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REPLAY   = 2'd2
    } ctrl_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RESULT_SEL_ALU = 2'b00;
    localparam logic [1:0] RESULT_SEL_MEM = 2'b01;
    localparam logic [1:0] RESULT_SEL_PC4 = 2'b10;

    // One bundle of the per-register hold/flush controls.
    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic bubble_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
    } pipe_ctrl_t;

endpackage

// File: rtl/forward_sel.sv
// EX-stage operand bypass select: the MEM-stage producer wins over the WB-stage
// producer, and register x0 is never bypassed.
module forward_sel
    import cpu_ctrl_pkg::*;
#(
    parameter int REGISTER_ADDR_WIDTH = 5
) (
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs_i,
    input  logic                           reg_write_mem_i,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_mem_i,
    input  logic                           reg_write_wb_i,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_wb_i,
    output logic [1:0]                     sel_o
);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = reg_write_mem_i && (rd_mem_i != '0) && (rd_mem_i == rs_i);
    assign hit_wb  = reg_write_wb_i  && (rd_wb_i  != '0) && (rd_wb_i  == rs_i);

    always_comb begin
        sel_o = FWD_RF;
        if (hit_mem) begin
            sel_o = FWD_MEM;
        end else if (hit_wb) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: stall/flush generation, EX forwarding selects,
// data-memory wait sequencing and stall/flush performance counters.
module hazard_ctrl_unit #(
    parameter int         REGISTER_ADDR_WIDTH = 5,
    parameter int         CNT_WIDTH           = 32,
    parameter logic [1:0] RESULT_SEL_MEM      = cpu_ctrl_pkg::RESULT_SEL_MEM
) (
    input  logic                           cpu_clk,
    input  logic                           cpu_rst_n,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_IF_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_IF_ID,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID_EX,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID_EX,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_ID_EX,
    input  logic [1:0]                     result_sel_ID_EX,
    input  logic                           reg_write_EX_MEM,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX_MEM,
    input  logic                           reg_write_MEM_WB,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_MEM_WB,
    input  logic                           pc_redirect_EX,
    input  logic                           dmem_req_MEM,
    input  logic                           dmem_ready,
    output logic                           stall_PC,
    output logic                           stall_IF_ID,
    output logic                           stall_ID_EX,
    output logic                           stall_EX_MEM,
    output logic                           bubble_MEM_WB,
    output logic                           flush_IF_ID,
    output logic                           flush_ID_EX,
    output logic [1:0]                     forward_a_EX,
    output logic [1:0]                     forward_b_EX,
    output logic [CNT_WIDTH-1:0]           stall_cnt,
    output logic [CNT_WIDTH-1:0]           flush_cnt,
    output logic [1:0]                     state_o
);

    import cpu_ctrl_pkg::ctrl_state_e;
    import cpu_ctrl_pkg::pipe_ctrl_t;
    import cpu_ctrl_pkg::ST_RUN;
    import cpu_ctrl_pkg::ST_MEM_WAIT;
    import cpu_ctrl_pkg::ST_REPLAY;

    ctrl_state_e          state_q;
    ctrl_state_e          state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_d;

    pipe_ctrl_t ctrl;
    logic       mem_pending;
    logic       mem_freeze;
    logic       load_use;

    // Operand A compares rs1_ID_EX, operand B compares rs2_ID_EX.
    logic [REGISTER_ADDR_WIDTH-1:0] rs_ex [2];
    logic [1:0]                     fwd_sel [2];

    assign rs_ex[0] = rs1_ID_EX;
    assign rs_ex[1] = rs2_ID_EX;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        forward_sel #(
            .REGISTER_ADDR_WIDTH(REGISTER_ADDR_WIDTH)
        ) u_forward_sel (
            .rs_i           (rs_ex[gi]),
            .reg_write_mem_i(reg_write_EX_MEM),
            .rd_mem_i       (rd_EX_MEM),
            .reg_write_wb_i (reg_write_MEM_WB),
            .rd_wb_i        (rd_MEM_WB),
            .sel_o          (fwd_sel[gi])
        );
    end

    assign forward_a_EX = fwd_sel[0];
    assign forward_b_EX = fwd_sel[1];

    assign mem_pending = dmem_req_MEM && !dmem_ready;
    assign mem_freeze  = (state_q == ST_MEM_WAIT) || mem_pending;
    assign load_use    = (result_sel_ID_EX == RESULT_SEL_MEM) && (rd_ID_EX != '0)
                      && ((rd_ID_EX == rs1_IF_ID) || (rd_ID_EX == rs2_IF_ID));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN, ST_REPLAY: state_d = mem_pending ? ST_MEM_WAIT : ST_RUN;
            ST_MEM_WAIT:       state_d = dmem_ready ? ST_REPLAY : ST_MEM_WAIT;
            default:           state_d = ST_RUN;
        endcase
    end

    // A frozen pipeline ignores redirect and load-use; the held inputs
    // present them again once the freeze lifts.
    always_comb begin
        ctrl = '0;
        if (mem_freeze) begin
            ctrl.stall_pc      = 1'b1;
            ctrl.stall_if_id   = 1'b1;
            ctrl.stall_id_ex   = 1'b1;
            ctrl.stall_ex_mem  = 1'b1;
            ctrl.bubble_mem_wb = 1'b1;
        end else if (pc_redirect_EX) begin
            ctrl.flush_if_id   = 1'b1;
            ctrl.flush_id_ex   = 1'b1;
        end else if (load_use) begin
            ctrl.stall_pc      = 1'b1;
            ctrl.stall_if_id   = 1'b1;
            ctrl.flush_id_ex   = 1'b1;
        end
    end

    assign stall_PC      = ctrl.stall_pc;
    assign stall_IF_ID   = ctrl.stall_if_id;
    assign stall_ID_EX   = ctrl.stall_id_ex;
    assign stall_EX_MEM  = ctrl.stall_ex_mem;
    assign bubble_MEM_WB = ctrl.bubble_mem_wb;
    assign flush_IF_ID   = ctrl.flush_if_id;
    assign flush_ID_EX   = ctrl.flush_id_ex;

    assign stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, ctrl.stall_pc};
    assign flush_cnt_d = flush_cnt_q + {{(CNT_WIDTH-1){1'b0}}, ctrl.flush_id_ex};

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: vector table, hand-written multi-cycle sequences
// and a randomized run against a rule-level reference model.
module tb_hazard_ctrl_unit;

    logic       cpu_clk = 1'b0;
    logic       cpu_rst_n;
    logic [4:0] rs1_IF_ID, rs2_IF_ID, rs1_ID_EX, rs2_ID_EX, rd_ID_EX;
    logic [1:0] result_sel_ID_EX;
    logic       reg_write_EX_MEM, reg_write_MEM_WB;
    logic [4:0] rd_EX_MEM, rd_MEM_WB;
    logic       pc_redirect_EX, dmem_req_MEM, dmem_ready;

    logic        stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, bubble_MEM_WB;
    logic        flush_IF_ID, flush_ID_EX;
    logic [1:0]  forward_a_EX, forward_b_EX, state_o;
    logic [31:0] stall_cnt, flush_cnt;

    logic        n_stall_PC, n_stall_IF_ID, n_stall_ID_EX, n_stall_EX_MEM, n_bubble_MEM_WB;
    logic        n_flush_IF_ID, n_flush_ID_EX;
    logic [1:0]  n_forward_a_EX, n_forward_b_EX, n_state_o;
    logic [3:0]  n_stall_cnt, n_flush_cnt;

    always #5 cpu_clk = ~cpu_clk;

    hazard_ctrl_unit dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
        .rs1_ID_EX(rs1_ID_EX), .rs2_ID_EX(rs2_ID_EX), .rd_ID_EX(rd_ID_EX),
        .result_sel_ID_EX(result_sel_ID_EX),
        .reg_write_EX_MEM(reg_write_EX_MEM), .rd_EX_MEM(rd_EX_MEM),
        .reg_write_MEM_WB(reg_write_MEM_WB), .rd_MEM_WB(rd_MEM_WB),
        .pc_redirect_EX(pc_redirect_EX), .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
        .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
        .stall_EX_MEM(stall_EX_MEM), .bubble_MEM_WB(bubble_MEM_WB),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
        .forward_a_EX(forward_a_EX), .forward_b_EX(forward_b_EX),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_o(state_o)
    );

    // Narrow-counter instance so wrap-around is reachable in a short run.
    hazard_ctrl_unit #(.CNT_WIDTH(4)) dut_narrow (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
        .rs1_ID_EX(rs1_ID_EX), .rs2_ID_EX(rs2_ID_EX), .rd_ID_EX(rd_ID_EX),
        .result_sel_ID_EX(result_sel_ID_EX),
        .reg_write_EX_MEM(reg_write_EX_MEM), .rd_EX_MEM(rd_EX_MEM),
        .reg_write_MEM_WB(reg_write_MEM_WB), .rd_MEM_WB(rd_MEM_WB),
        .pc_redirect_EX(pc_redirect_EX), .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
        .stall_PC(n_stall_PC), .stall_IF_ID(n_stall_IF_ID), .stall_ID_EX(n_stall_ID_EX),
        .stall_EX_MEM(n_stall_EX_MEM), .bubble_MEM_WB(n_bubble_MEM_WB),
        .flush_IF_ID(n_flush_IF_ID), .flush_ID_EX(n_flush_ID_EX),
        .forward_a_EX(n_forward_a_EX), .forward_b_EX(n_forward_b_EX),
        .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt), .state_o(n_state_o)
    );

    // Control vector order: stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
    // bubble_MEM_WB, flush_IF_ID, flush_ID_EX.
    logic [6:0] ctrl_act, n_ctrl_act;
    assign ctrl_act   = {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
                         bubble_MEM_WB, flush_IF_ID, flush_ID_EX};
    assign n_ctrl_act = {n_stall_PC, n_stall_IF_ID, n_stall_ID_EX, n_stall_EX_MEM,
                         n_bubble_MEM_WB, n_flush_IF_ID, n_flush_ID_EX};

    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_FREEZE = 7'b1111100;
    localparam logic [6:0] C_REDIR  = 7'b0000011;
    localparam logic [6:0] C_LDUSE  = 7'b1100001;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit     m_waiting;   // memory access outstanding, pipeline frozen
    bit     m_released;  // first cycle after the wait ended
    longint m_stalls, m_flushes;

    function automatic logic [6:0] model_ctrl();
        bit busy, lu;
        busy = m_waiting || (dmem_req_MEM && !dmem_ready);
        lu   = (result_sel_ID_EX == 2'b01) && (rd_ID_EX != 0)
            && (rd_ID_EX == rs1_IF_ID || rd_ID_EX == rs2_IF_ID);
        if (busy)           return C_FREEZE;
        if (pc_redirect_EX) return C_REDIR;
        if (lu)             return C_LDUSE;
        return C_NONE;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        logic [4:0] src_rd [2];
        logic       src_we [2];
        logic [1:0] src_code [2];
        src_rd[0] = rd_EX_MEM; src_we[0] = reg_write_EX_MEM; src_code[0] = 2'b10;
        src_rd[1] = rd_MEM_WB; src_we[1] = reg_write_MEM_WB; src_code[1] = 2'b01;
        for (int k = 0; k < 2; k++)
            if (src_we[k] && src_rd[k] != 0 && src_rd[k] == rs) return src_code[k];
        return 2'b00;
    endfunction

    function automatic logic [1:0] model_state();
        if (m_waiting)  return 2'd1;
        if (m_released) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_edge();
        logic [6:0] c;
        c = model_ctrl();
        if (!cpu_rst_n) begin
            m_waiting = 0; m_released = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (c[6]) m_stalls++;
            if (c[0]) m_flushes++;
            if (m_waiting) begin
                m_released = dmem_ready;
                m_waiting  = !dmem_ready;
            end else begin
                m_released = 0;
                m_waiting  = dmem_req_MEM && !dmem_ready;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ctrl"},     64'(ctrl_act),     64'(model_ctrl()));
        chk({tag, ".fwd_a"},    64'(forward_a_EX), 64'(model_fwd(rs1_ID_EX)));
        chk({tag, ".fwd_b"},    64'(forward_b_EX), 64'(model_fwd(rs2_ID_EX)));
        chk({tag, ".state"},    64'(state_o),      64'(model_state()));
        chk({tag, ".stall_cnt"}, 64'(stall_cnt),   64'(m_stalls % 64'h1_0000_0000));
        chk({tag, ".flush_cnt"}, 64'(flush_cnt),   64'(m_flushes % 64'h1_0000_0000));
        chk({tag, ".n_ctrl"},   64'({n_ctrl_act, n_forward_a_EX, n_forward_b_EX, n_state_o}),
                                64'({model_ctrl(), model_fwd(rs1_ID_EX), model_fwd(rs2_ID_EX),
                                     model_state()}));
        chk({tag, ".n_cnts"},   64'({n_stall_cnt, n_flush_cnt}),
                                64'({4'(m_stalls % 16), 4'(m_flushes % 16)}));
    endtask

    task automatic sample(input string tag);
        @(negedge cpu_clk);
        check_all(tag);
    endtask

    task automatic step();
        @(posedge cpu_clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        {rs1_IF_ID, rs2_IF_ID, rs1_ID_EX, rs2_ID_EX, rd_ID_EX} = '0;
        result_sel_ID_EX = 2'b00;
        {reg_write_EX_MEM, reg_write_MEM_WB} = '0;
        {rd_EX_MEM, rd_MEM_WB} = '0;
        {pc_redirect_EX, dmem_req_MEM, dmem_ready} = '0;
    endtask

    task automatic do_reset();
        cpu_rst_n = 1'b0;
        step();
        cpu_rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic [4:0] rs1_if, rs2_if, rs1_ex, rs2_ex, rd_ex;
        logic [1:0] rsel;
        logic       we_mem; logic [4:0] rd_mem;
        logic       we_wb;  logic [4:0] rd_wb;
        logic       redir, req, rdy;
        logic [6:0] exp_ctrl;
        logic [1:0] exp_fa, exp_fb;
    } vec_t;

    vec_t vecs [12];

    initial begin
        clear_inputs();
        cpu_rst_n = 1'b0;
        m_waiting = 0; m_released = 0; m_stalls = 0; m_flushes = 0;

        //          name       rs1if rs2if rs1ex rs2ex rdex rsel  wem rdm wwb rdw red req rdy  ctrl     fa     fb
        vecs[0]  = '{"idle",   0,  0,  0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0, 0, C_NONE,  2'b00, 2'b00};
        vecs[1]  = '{"lu_rs1", 5,  1,  0,  0,  5, 2'b01, 0, 0, 0, 0, 0, 0, 0, C_LDUSE, 2'b00, 2'b00};
        vecs[2]  = '{"lu_rs2", 3,  9,  0,  0,  9, 2'b01, 0, 0, 0, 0, 0, 0, 0, C_LDUSE, 2'b00, 2'b00};
        vecs[3]  = '{"lu_x0",  0,  0,  0,  0,  0, 2'b01, 0, 0, 0, 0, 0, 0, 0, C_NONE,  2'b00, 2'b00};
        vecs[4]  = '{"alu_rd", 5,  5,  0,  0,  5, 2'b00, 0, 0, 0, 0, 0, 0, 0, C_NONE,  2'b00, 2'b00};
        vecs[5]  = '{"pc4_rd", 6,  2,  0,  0,  6, 2'b10, 0, 0, 0, 0, 0, 0, 0, C_NONE,  2'b00, 2'b00};
        vecs[6]  = '{"redir",  5,  0,  0,  0,  5, 2'b01, 0, 0, 0, 0, 1, 0, 0, C_REDIR, 2'b00, 2'b00};
        vecs[7]  = '{"fwd_mem",0,  0,  7,  7,  0, 2'b00, 1, 7, 1, 7, 0, 0, 0, C_NONE,  2'b10, 2'b10};
        vecs[8]  = '{"fwd_wb", 0,  0,  7,  0,  0, 2'b00, 1, 0, 1, 7, 0, 0, 0, C_NONE,  2'b01, 2'b00};
        vecs[9]  = '{"fwd_x0", 0,  0,  3,  0,  0, 2'b00, 0, 3, 1, 3, 0, 0, 0, C_NONE,  2'b01, 2'b00};
        vecs[10] = '{"fwd_nwe",0,  0, 12, 12,  0, 2'b00, 1,12, 0,12, 0, 0, 0, C_NONE,  2'b10, 2'b10};
        vecs[11] = '{"req_rdy",0,  0,  0,  0,  0, 2'b00, 0, 0, 0, 0, 0, 1, 1, C_NONE,  2'b00, 2'b00};

        do_reset();
        sample("after_reset");
        chk("reset.stall_cnt", 64'(stall_cnt), 64'd0);
        chk("reset.flush_cnt", 64'(flush_cnt), 64'd0);
        chk("reset.state",     64'(state_o),   64'd0);

        foreach (vecs[i]) begin
            rs1_IF_ID = vecs[i].rs1_if;  rs2_IF_ID = vecs[i].rs2_if;
            rs1_ID_EX = vecs[i].rs1_ex;  rs2_ID_EX = vecs[i].rs2_ex;
            rd_ID_EX  = vecs[i].rd_ex;   result_sel_ID_EX = vecs[i].rsel;
            reg_write_EX_MEM = vecs[i].we_mem; rd_EX_MEM = vecs[i].rd_mem;
            reg_write_MEM_WB = vecs[i].we_wb;  rd_MEM_WB = vecs[i].rd_wb;
            pc_redirect_EX = vecs[i].redir;
            dmem_req_MEM = vecs[i].req;  dmem_ready = vecs[i].rdy;
            sample(vecs[i].name);
            chk({vecs[i].name, ".tbl_ctrl"}, 64'(ctrl_act),     64'(vecs[i].exp_ctrl));
            chk({vecs[i].name, ".tbl_fa"},   64'(forward_a_EX), 64'(vecs[i].exp_fa));
            chk({vecs[i].name, ".tbl_fb"},   64'(forward_b_EX), 64'(vecs[i].exp_fb));
            $display("vec %0d %s ctrl=%b fa=%b fb=%b", i, vecs[i].name, ctrl_act,
                     forward_a_EX, forward_b_EX);
            step();
        end

        // Load-use then dependency gone: exactly one bubble.
        clear_inputs(); do_reset();
        result_sel_ID_EX = 2'b01; rd_ID_EX = 5; rs1_IF_ID = 5;
        sample("lu_seq1");
        chk("lu_seq1.ctrl", 64'(ctrl_act), 64'(C_LDUSE));
        step();
        rd_ID_EX = 0;
        sample("lu_seq2");
        chk("lu_seq2.ctrl",  64'(ctrl_act),  64'(C_NONE));
        chk("lu_seq2.stall", 64'(stall_cnt), 64'd1);
        chk("lu_seq2.flush", 64'(flush_cnt), 64'd1);
        $display("seq load_use stall_cnt=%0d flush_cnt=%0d", stall_cnt, flush_cnt);
        step();

        // Redirect beats load-use.
        clear_inputs(); do_reset();
        result_sel_ID_EX = 2'b01; rd_ID_EX = 5; rs1_IF_ID = 5; pc_redirect_EX = 1;
        sample("redir_seq1");
        chk("redir_seq1.ctrl", 64'(ctrl_act), 64'(C_REDIR));
        step();
        clear_inputs();
        sample("redir_seq2");
        chk("redir_seq2.stall", 64'(stall_cnt), 64'd0);
        chk("redir_seq2.flush", 64'(flush_cnt), 64'd1);
        $display("seq redirect stall_cnt=%0d flush_cnt=%0d", stall_cnt, flush_cnt);
        step();

        // Memory wait: three frozen cycles, then REPLAY, then RUN.
        clear_inputs(); do_reset();
        dmem_req_MEM = 1; dmem_ready = 0; pc_redirect_EX = 1;
        sample("mw_c1");
        chk("mw_c1.ctrl",  64'(ctrl_act), 64'(C_FREEZE));
        chk("mw_c1.state", 64'(state_o),  64'd0);
        step();
        sample("mw_c2");
        chk("mw_c2.ctrl",  64'(ctrl_act), 64'(C_FREEZE));
        chk("mw_c2.state", 64'(state_o),  64'd1);
        step();
        dmem_ready = 1;
        sample("mw_c3");
        chk("mw_c3.ctrl",  64'(ctrl_act), 64'(C_FREEZE));
        chk("mw_c3.state", 64'(state_o),  64'd1);
        step();
        clear_inputs();
        sample("mw_c4");
        chk("mw_c4.ctrl",  64'(ctrl_act),  64'(C_NONE));
        chk("mw_c4.state", 64'(state_o),   64'd2);
        chk("mw_c4.stall", 64'(stall_cnt), 64'd3);
        step();
        sample("mw_c5");
        chk("mw_c5.state", 64'(state_o), 64'd0);
        $display("seq mem_wait stall_cnt=%0d state=%0d", stall_cnt, state_o);
        step();

        // Reset while waiting abandons the wait.
        clear_inputs(); do_reset();
        dmem_req_MEM = 1;
        sample("rw_c1"); step();
        sample("rw_c2"); step();
        cpu_rst_n = 0;
        sample("rw_rst"); step();
        cpu_rst_n = 1; dmem_req_MEM = 0;
        sample("rw_after");
        chk("rw_after.state", 64'(state_o),   64'd0);
        chk("rw_after.stall", 64'(stall_cnt), 64'd0);
        chk("rw_after.flush", 64'(flush_cnt), 64'd0);
        chk("rw_after.ctrl",  64'(ctrl_act),  64'(C_NONE));
        $display("seq reset_mid_wait state=%0d stall_cnt=%0d", state_o, stall_cnt);
        step();

        // Counter wrap on the 4-bit instance.
        clear_inputs(); do_reset();
        result_sel_ID_EX = 2'b01; rd_ID_EX = 4; rs2_IF_ID = 4;
        for (int k = 0; k < 16; k++) begin
            sample("wrap"); step();
        end
        sample("wrap16");
        chk("wrap16.n_stall", 64'(n_stall_cnt), 64'd0);
        chk("wrap16.stall",   64'(stall_cnt),   64'd16);
        step();
        sample("wrap17");
        chk("wrap17.n_stall", 64'(n_stall_cnt), 64'd1);
        $display("seq wrap narrow_stall_cnt=%0d stall_cnt=%0d", n_stall_cnt, stall_cnt);
        step();

        // Randomized run against the model.
        clear_inputs(); do_reset();
        for (int k = 0; k < 3000; k++) begin
            rs1_IF_ID = 5'($urandom_range(0, 7)); rs2_IF_ID = 5'($urandom_range(0, 7));
            rs1_ID_EX = 5'($urandom_range(0, 7)); rs2_ID_EX = 5'($urandom_range(0, 7));
            rd_ID_EX  = 5'($urandom_range(0, 7)); result_sel_ID_EX = 2'($urandom_range(0, 3));
            reg_write_EX_MEM = 1'($urandom); rd_EX_MEM = 5'($urandom_range(0, 7));
            reg_write_MEM_WB = 1'($urandom); rd_MEM_WB = 5'($urandom_range(0, 7));
            pc_redirect_EX = ($urandom_range(0, 5) == 0);
            dmem_req_MEM   = ($urandom_range(0, 2) == 0);
            dmem_ready     = 1'($urandom);
            cpu_rst_n      = ($urandom_range(0, 63) != 0);
            sample("rand");
            if (k % 500 == 0)
                $display("rand %0d state=%0d ctrl=%b stall_cnt=%0d flush_cnt=%0d",
                         k, state_o, ctrl_act, stall_cnt, flush_cnt);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
